// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: radix-2 restoring divider, registered multiplier,
// pipeline stall generation and a single-cycle {hi,lo} write strobe.
module muldiv_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        stall,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_SIGN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        in_signed_div;
  logic [31:0] mag_a, mag_b;
  logic [63:0] ext_a, ext_b, product;
  logic [32:0] shifted;
  logic        ge;

  always_comb begin
    in_signed_div = (op == 2'b10);
    mag_a = (in_signed_div && src_a[31]) ? -src_a : src_a;
    mag_b = (in_signed_div && src_b[31]) ? -src_b : src_b;

    // Extending to 64 bits makes one truncated multiply serve both MULT and MULTU.
    ext_a   = op_q[0] ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
    ext_b   = op_q[0] ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
    product = ext_a * ext_b;

    shifted = {rem_q, quo_q[31]};
    ge      = (shifted >= {1'b0, b_q});

    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = op;
          a_d  = src_a;
          b_d  = src_b;
          if (!op[1]) begin
            state_d = S_MUL;
            cnt_d   = 5'(MUL_LAT - 1);
          end else if (src_b == 32'd0) begin
            state_d = S_DONE;
            hi_d    = src_a;
            lo_d    = 32'hFFFF_FFFF;
          end else begin
            state_d = S_DIV;
            cnt_d   = 5'd31;
            rem_d   = 32'd0;
            quo_d   = mag_a;
            b_d     = mag_b;
            qneg_d  = in_signed_div & (src_a[31] ^ src_b[31]);
            rneg_d  = in_signed_div & src_a[31];
          end
        end
      end
      S_MUL: begin
        if (cnt_q == 5'd0) begin
          state_d = S_DONE;
          hi_d    = product[63:32];
          lo_d    = product[31:0];
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DIV: begin
        // Dividend bits shift out of quo_q's top while quotient bits shift in at the bottom.
        rem_d = ge ? 32'(shifted - {1'b0, b_q}) : shifted[31:0];
        quo_d = {quo_q[30:0], ge};
        if (cnt_q == 5'd0) state_d = S_SIGN;
        else               cnt_d   = cnt_q - 5'd1;
      end
      S_SIGN: begin
        state_d = S_DONE;
        lo_d    = qneg_q ? -quo_q : quo_q;
        hi_d    = rneg_q ? -rem_q : rem_q;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A flush abandons the operation and must leave the architectural HI/LO untouched.
    if (cancel) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      cnt_q   <= 5'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign stall        = !cancel && (((state_q == S_IDLE) && start) || (state_q == S_MUL) ||
                                    (state_q == S_DIV) || (state_q == S_SIGN));
  assign result_valid = (state_q == S_DONE) && !cancel;
  assign hi           = hi_q;
  assign lo           = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed vector table, cancel/reset sequences and random ops
// checked against an arithmetic reference model.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        cancel = 1'b0;
  logic        stall, busy, result_valid;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  muldiv_ctrl #(.MUL_LAT(1)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .stall(stall), .busy(busy), .result_valid(result_valid),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: architectural HI/LO result from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] t, tq, tr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 2'b00) begin
      q = sa * sb;
      t = q;
    end else if (o == 2'b01) begin
      t = {32'b0, a} * {32'b0, b};
    end else if (b == 32'd0) begin
      t = {a, 32'hFFFF_FFFF};
    end else if (o == 2'b11) begin
      t = {a % b, a / b};
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      tq = q;
      tr = r;
      t  = {tr[31:0], tq[31:0]};
    end
    return t;
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] b);
    if (!o[1])      return 2;
    if (b == 32'd0) return 1;
    return 34;
  endfunction

  // Launches one op in the next cycle (cycle 0), holds start until the result strobe.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int elat,
                        input string nm);
    int got;
    logic bad;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    got = -1;
    bad = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (result_valid) begin
        got = c;
        break;
      end
      if (!stall || (c > 0 && !busy)) bad = 1'b1;
    end
    chk({nm, "_latency"}, 64'(got), 64'(elat));
    chk({nm, "_stall_busy_while_running"}, {63'b0, bad}, 64'd0);
    chk({nm, "_stall_in_done"}, {63'b0, stall}, 64'd0);
    chk({nm, "_hilo"}, {hi, lo}, {eh, el});
    start = 1'b0;
    last_hi = eh;
    last_lo = el;
  endtask

  initial begin
    logic [63:0] m;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic        rv_seen;

    tv[0] = '{2'b11, 32'd100,        32'd7,          32'd2,          32'd14,         34};
    tv[1] = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  34};
    tv[2] = '{2'b00, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF,  32'hFFFF_FFF1,  2};
    tv[3] = '{2'b01, 32'hFFFF_FFFD,  32'd5,          32'h0000_0004,  32'hFFFF_FFF1,  2};
    tv[4] = '{2'b11, 32'd1234,       32'd0,          32'd1234,       32'hFFFF_FFFF,  1};
    tv[5] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  34};
    tv[6] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  34};

    #3;
    chk("reset_stall", {63'b0, stall}, 64'd0);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_result_valid", {63'b0, result_valid}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo, tv[i].lat, $sformatf("vec%0d", i));

    @(negedge clk);
    #1;
    chk("hilo_hold_after_done", {hi, lo}, {last_hi, last_lo});
    chk("idle_after_done", {62'b0, busy, result_valid}, 64'd0);

    // DIV flushed at cycle 10, followed by MULTU launched at cycle 12.
    @(negedge clk);
    start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
    rv_seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (result_valid) rv_seen = 1'b1;
    end
    cancel = 1'b1;
    #1;
    chk("cancel_stall_drop", {63'b0, stall}, 64'd0);
    chk("cancel_busy_same_cycle", {63'b0, busy}, 64'd1);
    chk("cancel_no_valid_same_cycle", {63'b0, result_valid}, 64'd0);
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    #1;
    if (result_valid) rv_seen = 1'b1;
    chk("cancel_busy_next", {63'b0, busy}, 64'd0);
    chk("cancel_no_result", {63'b0, rv_seen}, 64'd0);
    chk("cancel_hilo_kept", {hi, lo}, {last_hi, last_lo});
    run_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 2, "multu_after_cancel");

    // Cancel and start together in IDLE: nothing launched.
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd3;
    #1;
    chk("start_cancel_stall", {63'b0, stall}, 64'd0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    #1;
    chk("start_cancel_idle", {62'b0, busy, result_valid}, 64'd0);
    chk("start_cancel_hilo", {hi, lo}, {last_hi, last_lo});

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 2'b11; src_a = 32'd500; src_b = 32'd9;
    repeat (20) @(negedge clk);
    #2;
    resetn = 1'b0;
    start = 1'b0;
    #1;
    chk("midreset_busy", {63'b0, busy}, 64'd0);
    chk("midreset_stall", {63'b0, stall}, 64'd0);
    chk("midreset_valid", {63'b0, result_valid}, 64'd0);
    chk("midreset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op(2'b11, 32'd500, 32'd9, 32'd5, 32'd55, 34, "divu_after_reset");

    // Random ops, back to back, against the reference model.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 9);
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      m = model(ro, ra, rb);
      run_op(ro, ra, rb, m[63:32], m[31:0], model_lat(ro, rb), $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
